// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the shift register serdes.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    SR_HOLD = 2'b00,
    SR_SHL  = 2'b01,
    SR_SHR  = 2'b10,
    SR_LOAD = 2'b11
  } shift_mode_t;

  // Frame length 0 means a full-width frame; lengths beyond the width clamp to it.
  function automatic int unsigned eff_len(input int unsigned depth, input int unsigned len);
    return (len == 0 || len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/shift_frame_counter.sv
// Counts shifts within a frame and emits a one-cycle registered done pulse.
module shift_frame_counter
  import shift_reg_pkg::*;
#(
  parameter int unsigned DEPTH = 24,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic             advance,
  input  logic             restart,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [CNT_W-1:0] w_last;

  assign w_last = CNT_W'(eff_len(DEPTH, 32'(len)) - 32'd1);

  // A count past w_last (after a mid-frame shrink) wraps modularly without a pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (clear || restart) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (advance) begin
      if (r_cnt == w_last) begin
        r_cnt  <= '0;
        r_done <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign cnt  = r_cnt;
  assign done = r_done;

endmodule

// File: rtl/shift_reg_serdes.sv
// Bidirectional shift register with parallel load and frame counting;
// serves as serializer or deserializer between pins and parallel registers.
module shift_reg_serdes
  import shift_reg_pkg::*;
#(
  parameter int unsigned DEPTH = 24,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic             ser_in_lsb,
  input  logic             ser_in_msb,
  input  logic [DEPTH-1:0] p_in,
  input  logic [CNT_W-1:0] frame_len,
  output logic [DEPTH-1:0] p_out,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_done
);

  shift_mode_t      w_mode;
  logic             w_advance;
  logic             w_restart;
  logic [DEPTH-1:0] r_data;

  assign w_mode    = shift_mode_t'(mode);
  assign w_advance = (w_mode == SR_SHL) || (w_mode == SR_SHR);
  assign w_restart = (w_mode == SR_LOAD);

  // Data register and mode mux.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_data <= '0;
    end else if (clear) begin
      r_data <= '0;
    end else begin
      case (w_mode)
        SR_SHL:  r_data <= {r_data[DEPTH-2:0], ser_in_lsb};
        SR_SHR:  r_data <= {ser_in_msb, r_data[DEPTH-1:1]};
        SR_LOAD: r_data <= p_in;
        default: r_data <= r_data;
      endcase
    end
  end

  shift_frame_counter #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .nrst    (nrst),
    .clear   (clear),
    .advance (w_advance),
    .restart (w_restart),
    .len     (frame_len),
    .cnt     (bit_cnt),
    .done    (frame_done)
  );

  assign p_out       = r_data;
  assign ser_out_msb = r_data[DEPTH-1];
  assign ser_out_lsb = r_data[0];

endmodule
